// File: rtl/pong_pkg.sv
// Shared constants and types for the pong game-state engine.
// Grid is 20x15 cells; paddles span five rows from their top position.
package pong_pkg;
  localparam int W          = 20;
  localparam int H          = 15;
  localparam int PADDLE     = 4;
  localparam int CENTER_X   = 10;
  localparam int CENTER_Y   = 7;
  localparam int PADDLE_MAX = H - 1 - PADDLE;

  typedef enum logic [1:0] {S_IDLE, S_PLAY, S_POINT, S_OVER} state_t;

  // DIR_POS is right for dx and down for dy.
  typedef enum logic {DIR_POS, DIR_NEG} dir_t;

  typedef struct packed {
    logic [4:0] x;
    logic [3:0] y;
    dir_t       dx;
    dir_t       dy;
  } ball_t;

  function automatic logic in_paddle(input logic [3:0] pos, input logic [3:0] y);
    return ({1'b0, y} >= {1'b0, pos}) && ({1'b0, y} <= {1'b0, pos} + 5'(PADDLE));
  endfunction
endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every DIV clocks (DIV >= 2).
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
endmodule

// File: rtl/pong_game_engine.sv
// Pong game state: ball, player/computer paddles, scores and match FSM.
// All motion advances on the game tick; outputs are grid-cell coordinates.
module pong_game_engine
  import pong_pkg::*;
#(
  parameter int TICK_DIV    = 2500000,
  parameter int COM_DIV     = 2,
  parameter int POINT_TICKS = 10,
  parameter int WIN_SCORE   = 9
) (
  input  logic       CLK_IN,
  input  logic       RESET_N,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [4:0] ballX,
  output logic [3:0] ballY,
  output logic [3:0] playerPos,
  output logic [3:0] comPos,
  output logic [3:0] playerScore,
  output logic [3:0] comScore,
  output logic       game_over
);
  localparam int CCW = $clog2(COM_DIV + 1);
  localparam int PCW = $clog2(POINT_TICKS + 1);

  logic           tick;
  logic [1:0]     up_sync, dn_sync;
  logic [2:0]     st_sync;
  logic           up_s, dn_s, start_pulse;
  state_t         state, state_nxt;
  ball_t          ball, ball_nxt;
  dir_t           serve_dx;
  logic [CCW-1:0] com_cnt;
  logic [PCW-1:0] pt_cnt;
  logic           miss_l, miss_r, pt_done, win;
  logic           play_tick, point_tick, paddle_tick, serve, clear_all;

  tick_gen #(.DIV(TICK_DIV)) u_tick (.clk(CLK_IN), .rst_n(RESET_N), .tick(tick));

  // Two-flop synchronisers; the third start flop only feeds the edge detect.
  always_ff @(posedge CLK_IN or negedge RESET_N)
    if (!RESET_N) begin
      up_sync <= '0;
      dn_sync <= '0;
      st_sync <= '0;
    end else begin
      up_sync <= {up_sync[0], btn_up};
      dn_sync <= {dn_sync[0], btn_down};
      st_sync <= {st_sync[1:0], btn_start};
    end

  assign up_s        = up_sync[1];
  assign dn_s        = dn_sync[1];
  assign start_pulse = st_sync[1] & ~st_sync[2];

  assign pt_done = (pt_cnt == PCW'(POINT_TICKS - 1));
  assign win     = (playerScore == 4'(WIN_SCORE)) || (comScore == 4'(WIN_SCORE));

  // Ball step from pre-tick values; vertical flip is applied before the move.
  always_comb begin
    ball_nxt = ball;
    miss_l   = 1'b0;
    miss_r   = 1'b0;
    if ((ball.dy == DIR_POS && ball.y == 4'(H - 1)) || (ball.dy == DIR_NEG && ball.y == 4'd0))
      ball_nxt.dy = dir_t'(~ball.dy);
    ball_nxt.y = (ball_nxt.dy == DIR_POS) ? ball.y + 4'd1 : ball.y - 4'd1;
    if (ball.dx == DIR_NEG && ball.x == 5'd1) begin
      if (in_paddle(playerPos, ball.y)) begin
        ball_nxt.dx = DIR_POS;
        ball_nxt.x  = 5'd2;
      end else begin
        ball_nxt.x = 5'd0;
        miss_l     = 1'b1;
      end
    end else if (ball.dx == DIR_POS && ball.x == 5'(W - 2)) begin
      if (in_paddle(comPos, ball.y)) begin
        ball_nxt.dx = DIR_NEG;
        ball_nxt.x  = 5'(W - 3);
      end else begin
        ball_nxt.x = 5'(W - 1);
        miss_r     = 1'b1;
      end
    end else begin
      ball_nxt.x = (ball.dx == DIR_POS) ? ball.x + 5'd1 : ball.x - 5'd1;
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_N)
    if (!RESET_N) state <= S_IDLE;
    else          state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_pulse) state_nxt = S_PLAY;
      S_PLAY:  if (tick && (miss_l || miss_r)) state_nxt = S_POINT;
      S_POINT: if (tick && pt_done) state_nxt = win ? S_OVER : S_PLAY;
      S_OVER:  if (start_pulse) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    game_over   = (state == S_OVER);
    play_tick   = tick && (state == S_PLAY);
    point_tick  = tick && (state == S_POINT);
    paddle_tick = tick && (state != S_OVER);
    serve       = start_pulse && (state == S_IDLE);
    clear_all   = start_pulse && (state == S_OVER);
  end

  always_ff @(posedge CLK_IN or negedge RESET_N)
    if (!RESET_N) begin
      ball        <= '{x: 5'(CENTER_X), y: 4'(CENTER_Y), dx: DIR_POS, dy: DIR_POS};
      serve_dx    <= DIR_POS;
      playerPos   <= 4'd5;
      comPos      <= 4'd5;
      playerScore <= '0;
      comScore    <= '0;
      com_cnt     <= '0;
      pt_cnt      <= '0;
    end else if (clear_all) begin
      ball        <= '{x: 5'(CENTER_X), y: 4'(CENTER_Y), dx: DIR_POS, dy: DIR_POS};
      playerPos   <= 4'd5;
      comPos      <= 4'd5;
      playerScore <= '0;
      comScore    <= '0;
    end else begin
      if (serve) begin
        ball.dx <= DIR_POS;
        ball.dy <= DIR_POS;
      end
      if (paddle_tick) begin
        if (up_s && !dn_s && playerPos != 4'd0)
          playerPos <= playerPos - 4'd1;
        else if (dn_s && !up_s && playerPos < 4'(PADDLE_MAX))
          playerPos <= playerPos + 4'd1;
      end
      if (play_tick) begin
        ball <= ball_nxt;
        if (com_cnt == CCW'(COM_DIV - 1)) begin
          com_cnt <= '0;
          if ({1'b0, comPos} + 5'd2 < {1'b0, ball.y} && comPos < 4'(PADDLE_MAX))
            comPos <= comPos + 4'd1;
          else if ({1'b0, comPos} + 5'd2 > {1'b0, ball.y} && comPos != 4'd0)
            comPos <= comPos - 4'd1;
        end else begin
          com_cnt <= com_cnt + 1'b1;
        end
        if (miss_l) begin
          serve_dx <= DIR_NEG;
          if (comScore != 4'(WIN_SCORE)) comScore <= comScore + 4'd1;
        end
        if (miss_r) begin
          serve_dx <= DIR_POS;
          if (playerScore != 4'(WIN_SCORE)) playerScore <= playerScore + 4'd1;
        end
      end
      if (point_tick) begin
        if (pt_done) begin
          pt_cnt <= '0;
          if (!win) begin
            ball.x  <= 5'(CENTER_X);
            ball.y  <= 4'(CENTER_Y);
            ball.dx <= serve_dx;
          end
        end else begin
          pt_cnt <= pt_cnt + 1'b1;
        end
      end
    end

  assign ballX = ball.x;
  assign ballY = ball.y;
endmodule
